sha_pad: RTL and testbench

- Message-padding stage that sits directly upstream of sha_block.
- Accepts the message as a byte stream and applies SHA-256 style padding: 0x80, zero fill, then the 64-bit big-endian bit length.
- Delivers complete NL-byte blocks on Data_Block with an Enable pulse and a Function flag (0 = first block of message, 1 = continuation).
- Holds each block stable until the consumer signals Ready_In.

---
 rtl/sha_pad.sv | 138 +++++++++++++
 tb/tb_sha_pad.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_pad.sv
// SHA-256 style message padder: buffers message bytes into NL-byte blocks,
// appends 0x80, zero fill and the big-endian bit length, and hands blocks downstream.
module sha_pad #(
    parameter int NL = 64,
    parameter int LW = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Data_In,
    input  logic       Valid_In,
    input  logic       Last_In,
    output logic       Accept,
    output logic [7:0] Data_Block [0:NL-1],
    output logic       Enable,
    output logic       Function,
    input  logic       Ready_In,
    output logic       Done
);

    localparam int CW = $clog2(NL + 1);
    localparam int IW = $clog2(NL);
    localparam int LB = LW / 8;
    localparam int BW = LW - 3;

    typedef enum logic [1:0] {ST_LOAD, ST_PAD, ST_EMIT, ST_WAIT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bytes;
    logic [7:0]    r_buf [0:NL-1];
    logic          r_pad_pending;
    logic          r_in_pad;
    logic          r_final;
    logic          r_func;
    logic          r_enable;
    logic          r_done;
    logic          r_accept;

    logic          w_acc;
    logic          w_put80;
    logic [CW-1:0] w_cnt_pad;
    logic          w_pp_after;
    logic          w_put_len;
    logic [LW-1:0] w_len;

    assign w_acc      = Valid_In && r_accept;
    assign w_put80    = r_pad_pending && (r_cnt < CW'(NL));
    assign w_cnt_pad  = r_cnt + (w_put80 ? CW'(1) : CW'(0));
    assign w_pp_after = r_pad_pending && !w_put80;
    // The length only fits when the 0x80 marker landed in front of the length field.
    assign w_put_len  = !w_pp_after && (w_cnt_pad <= CW'(NL - LB));
    assign w_len      = {r_bytes, 3'b000};

    assign Data_Block = r_buf;
    assign Accept     = r_accept;
    assign Enable     = r_enable;
    assign Function   = r_func;
    assign Done       = r_done;

    // Block assembly, padding and downstream handshake state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_LOAD;
            r_cnt         <= '0;
            r_bytes       <= '0;
            r_pad_pending <= 1'b0;
            r_in_pad      <= 1'b0;
            r_final       <= 1'b0;
            r_func        <= 1'b0;
            r_enable      <= 1'b0;
            r_done        <= 1'b0;
            r_accept      <= 1'b1;
            for (int i = 0; i < NL; i++) r_buf[i] <= 8'h00;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_acc) begin
                        r_buf[r_cnt[IW-1:0]] <= Data_In;
                        r_cnt   <= r_cnt + CW'(1);
                        r_bytes <= r_bytes + BW'(1);
                        if (Last_In) begin
                            r_pad_pending <= 1'b1;
                            r_in_pad      <= 1'b1;
                            r_accept      <= 1'b0;
                            r_state       <= ST_PAD;
                        end else if (r_cnt == CW'(NL - 1)) begin
                            r_accept <= 1'b0;
                            r_enable <= 1'b1;
                            r_state  <= ST_EMIT;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_put80) r_buf[r_cnt[IW-1:0]] <= 8'h80;
                    r_cnt         <= w_cnt_pad;
                    r_pad_pending <= w_pp_after;
                    if (w_put_len) begin
                        for (int k = 0; k < LB; k++) r_buf[NL-LB+k] <= w_len[LW-1-8*k -: 8];
                        r_final <= 1'b1;
                    end
                    r_enable <= 1'b1;
                    r_state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Ready_In) begin
                        for (int i = 0; i < NL; i++) r_buf[i] <= 8'h00;
                        r_cnt  <= '0;
                        r_func <= 1'b1;
                        if (r_final) begin
                            r_final  <= 1'b0;
                            r_in_pad <= 1'b0;
                            r_bytes  <= '0;
                            r_func   <= 1'b0;
                            r_done   <= 1'b1;
                            r_accept <= 1'b1;
                            r_state  <= ST_LOAD;
                        end else if (r_pad_pending || r_in_pad) begin
                            r_state <= ST_PAD;
                        end else begin
                            r_accept <= 1'b1;
                            r_state  <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_accept <= 1'b1;
                    r_state  <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_pad.sv
// Randomized scoreboard bench for sha_pad: a padding model queues expected blocks,
// a monitor checks every Enable, the hold in WAIT, and the Done pulse.
module tb_sha_pad;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [511:0] data;
        bit           func;
        bit           last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] Data_In;
    logic       Valid_In;
    logic       Last_In;
    logic       Ready_In;
    logic       Accept;
    logic       Enable;
    logic       Function;
    logic       Done;
    logic [7:0] Data_Block [0:63];

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   ready_mode = 0;
    int   done_seen = 0;
    int   msgs_exp = 0;
    bit   in_wait = 0;
    bit   done_due = 0;

    sha_pad #(.NL(64), .LW(64)) dut (
        .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
        .Last_In(Last_In), .Accept(Accept), .Data_Block(Data_Block),
        .Enable(Enable), .Function(Function), .Ready_In(Ready_In), .Done(Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [511:0] pack_dut();
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[511-8*i -: 8] = Data_Block[i];
        return v;
    endfunction

    // Reference: padded stream = msg, 0x80, zeros to 56 mod 64, 8-byte big-endian bit length
    task automatic push_model(input byte_q_t msg);
        byte_q_t      p;
        logic [63:0]  len;
        int           nb;
        exp_t         e;
        p   = msg;
        len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 64; i++) e.data[511-8*i -: 8] = p[64*b+i];
            e.func = (b != 0);
            e.last = (b == nb - 1);
            sb.push_back(e);
        end
        msgs_exp++;
    endtask

    initial begin
        Ready_In = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) Ready_In = 1'b1;
            else if (ready_mode == 1) Ready_In = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected blocks on Enable, checks hold during WAIT and the Done timing
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_wait  = 0;
                done_due = 0;
            end else begin
                if (done_due || Done) chk("done pulse", 512'(Done), 512'(done_due));
                if (Done) done_seen++;
                done_due = 0;
                if (in_wait) begin
                    chk("accept in wait", 512'(Accept), 512'd0);
                    chk("enable in wait", 512'(Enable), 512'd0);
                    chk("block held", pack_dut(), cur.data);
                    chk("function held", 512'(Function), 512'(cur.func));
                    if (Ready_In) begin
                        done_due = cur.last;
                        in_wait  = 0;
                    end
                end
                if (Enable) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected enable: got 1 want 0");
                    end else begin
                        cur = sb.pop_front();
                        chk("block data", pack_dut(), cur.data);
                        chk("function", 512'(Function), 512'(cur.func));
                        chk("accept at enable", 512'(Accept), 512'd0);
                        in_wait = 1;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
        int  t;
        bit  acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                Valid_In = 1'b0;
                Last_In  = 1'($urandom_range(0, 1));
                Data_In  = 8'($urandom_range(0, 255));
                @(posedge clk);
                #1;
            end
        end
        Valid_In = 1'b1;
        Data_In  = b;
        Last_In  = last;
        t = 0;
        forever begin
            @(negedge clk);
            acc = Accept;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 3000) begin
                chk("accept timeout", 512'd0, 512'd1);
                break;
            end
        end
        Valid_In = 1'b0;
        Last_In  = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit gaps);
        push_model(msg);
        for (int i = 0; i < msg.size(); i++) begin
            send_byte(msg[i], (i == msg.size() - 1), gaps);
            if (i == msg.size() - 1) begin
                @(negedge clk);
                chk("pad cycle no enable", 512'(Enable), 512'd0);
                @(negedge clk);
                chk("last byte latency", 512'(Enable), 512'd1);
            end else if ((i % 64) == 63) begin
                @(negedge clk);
                chk("full block latency", 512'(Enable), 512'd1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || in_wait || done_due) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) chk("drain timeout", 512'd0, 512'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " accept"}, 512'(Accept), 512'd1);
        chk({tag, " enable"}, 512'(Enable), 512'd0);
        chk({tag, " function"}, 512'(Function), 512'd0);
        chk({tag, " done"}, 512'(Done), 512'd0);
        chk({tag, " block"}, pack_dut(), 512'd0);
    endtask

    initial begin
        byte_q_t m;
        int      len;
        rst      = 1'b0;
        Valid_In = 1'b0;
        Last_In  = 1'b0;
        Data_In  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        ready_mode = 0;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_idle();

        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'hAA);
        send_msg(m, 1'b0);
        wait_idle();

        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'h11);
        send_msg(m, 1'b0);
        wait_idle();

        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        send_msg(m, 1'b0);
        wait_idle();

        ready_mode = 2;
        Ready_In   = 1'b0;
        m = {};
        for (int i = 0; i < 20; i++) m.push_back(8'($urandom_range(0, 255)));
        send_msg(m, 1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("backpressure accept", 512'(Accept), 512'd0);
        end
        @(posedge clk);
        #1;
        Ready_In = 1'b1;
        @(posedge clk);
        #1;
        Ready_In = 1'b0;
        @(negedge clk);
        chk("accept after ready", 512'(Accept), 512'd1);
        wait_idle();

        ready_mode = 1;
        for (int i = 0; i < 30; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_idle();

        for (int n = 0; n < 24; n++) begin
            case (n)
                0: len = 57;
                1: len = 63;
                2: len = 119;
                3: len = 120;
                4: len = 128;
                5: len = 1;
                default: len = $urandom_range(1, 150);
            endcase
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
            send_msg(m, 1'b1);
            wait_idle();
        end

        chk("done count", 512'(done_seen), 512'(msgs_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
